// File: rtl/picoblaze_io_hub_pkg.sv
// io_hub_pkg: shared types and constants for the PicoBlaze I/O hub
package io_hub_pkg;
    typedef enum logic {IDLE, PEND} irq_state_t;
    localparam int OVR_W = 7;
    localparam logic [OVR_W-1:0] OVR_MAX = 7'd127;
    localparam logic [7:0] STATUS_PORT_DEFAULT = 8'hFF;
endpackage

// File: rtl/picoblaze_io_hub_if.sv
// picoblaze_io_hub_if: KCPSM6 port bus between processor (master) and hub (slave)
interface picoblaze_io_hub_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic [7:0] io_data_in;
    logic [7:0] io_data_out;
    logic       interrupt;
    logic       interrupt_ack;
    modport master (
        output port_id, write_strobe, k_write_strobe, read_strobe, io_data_in, interrupt_ack,
        input  io_data_out, interrupt
    );
    modport slave (
        input  port_id, write_strobe, k_write_strobe, read_strobe, io_data_in, interrupt_ack,
        output io_data_out, interrupt
    );
endinterface

// File: rtl/picoblaze_io_hub_irq.sv
// io_hub_irq: latched update interrupt with saturating overrun counter
module io_hub_irq
    import io_hub_pkg::*;
(
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             upd_sysregs,
    input  logic             interrupt_ack,
    input  logic             clr_overrun,
    output logic             interrupt,
    output logic [OVR_W-1:0] overrun
);
    irq_state_t state, state_nx;
    logic inc;

    // state register and overrun counter; an increment coinciding with a clear leaves 1
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state   <= IDLE;
            overrun <= '0;
        end else begin
            state <= state_nx;
            if (clr_overrun)
                overrun <= {{(OVR_W-1){1'b0}}, inc};
            else if (inc && overrun != OVR_MAX)
                overrun <= overrun + 1'b1;
        end
    end

    // next state: a new update always (re)arms; an ack only clears when no new update arrives
    always_comb begin
        state_nx  = (upd_sysregs || (state == PEND && !interrupt_ack)) ? PEND : IDLE;
        inc       = state == PEND && upd_sysregs && !interrupt_ack;
        interrupt = state == PEND;
    end
endmodule

// File: rtl/picoblaze_io_hub.sv
// picoblaze_io_hub: KCPSM6 port-I/O hub with read/write register banks and update interrupt
// Define IO_HUB_SNAPSHOT_EN to read from shadow registers captured on upd_sysregs;
// otherwise reads return live in_regs.
module picoblaze_io_hub
    import io_hub_pkg::*;
#(
    parameter int         NUM_IN      = 8,
    parameter int         NUM_OUT     = 8,
    parameter logic [7:0] BASE_IN     = 8'h00,
    parameter logic [7:0] BASE_OUT    = 8'h00,
    parameter logic [7:0] STATUS_PORT = STATUS_PORT_DEFAULT,
    parameter logic [7:0] OUT_RESET   = 8'h00
)(
    input  logic                 sysclk,
    input  logic                 sysreset,
    picoblaze_io_hub_if.slave    bus,
    input  logic                 upd_sysregs,
    input  logic [NUM_IN*8-1:0]  in_regs,
    output logic [NUM_OUT*8-1:0] out_regs,
    output logic [NUM_OUT-1:0]   out_wr,
    output logic [NUM_IN-1:0]    in_rd
);
    logic [OVR_W-1:0]    overrun;
    logic [NUM_IN*8-1:0] src;
    logic [8:0]          in_off, out_off;
    logic                is_status;
    logic [7:0]          rd_data;
    logic [NUM_IN-1:0]   rd_sel;
    logic [NUM_OUT-1:0]  wr_sel;

    // 9-bit offsets: a borrow lands at >= 256, so it never matches a register index
    assign is_status = bus.port_id == STATUS_PORT;
    assign in_off    = {1'b0, bus.port_id} - {1'b0, BASE_IN};
    assign out_off   = {1'b0, bus.port_id} - {1'b0, BASE_OUT};

`ifdef IO_HUB_SNAPSHOT_EN
    logic [NUM_IN*8-1:0] shadow;

    // coherent snapshot of all read registers on each update strobe
    always_ff @(posedge sysclk) begin
        if (sysreset)
            shadow <= '0;
        else if (upd_sysregs)
            shadow <= in_regs;
    end

    assign src = shadow;
`else
    assign src = in_regs;
`endif

    io_hub_irq u_irq (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .upd_sysregs   (upd_sysregs),
        .interrupt_ack (bus.interrupt_ack),
        .clr_overrun   (bus.read_strobe && is_status),
        .interrupt     (bus.interrupt),
        .overrun       (overrun)
    );

    // read mux; the status port shadows any overlapping read register
    always_comb begin
        rd_data = is_status ? {bus.interrupt, overrun} : 8'h00;
        rd_sel  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!is_status && in_off == 9'(i)) begin
                rd_data   = src[8*i +: 8];
                rd_sel[i] = 1'b1;
            end
        end
    end

    // write decode; OUTPUTK only sees port_id[3:0]
    always_comb begin
        wr_sel = '0;
        for (int j = 0; j < NUM_OUT; j++)
            wr_sel[j] = (bus.write_strobe && out_off == 9'(j)) ||
                        (bus.k_write_strobe && !bus.write_strobe && bus.port_id[3:0] == 4'(j));
    end

    // registered read data, write registers and single-cycle access pulses
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            bus.io_data_out <= 8'h00;
            out_regs        <= {NUM_OUT{OUT_RESET}};
            out_wr          <= '0;
            in_rd           <= '0;
        end else begin
            bus.io_data_out <= rd_data;
            in_rd           <= bus.read_strobe ? rd_sel : '0;
            out_wr          <= wr_sel;
            for (int j = 0; j < NUM_OUT; j++)
                if (wr_sel[j])
                    out_regs[8*j +: 8] <= bus.io_data_in;
        end
    end
endmodule

// File: tb/tb_picoblaze_io_hub.sv
// tb_picoblaze_io_hub: randomized scoreboard bench for picoblaze_io_hub with a behavioural model
module tb_picoblaze_io_hub;
    localparam int         NI   = 8;
    localparam int         NO   = 8;
    localparam logic [7:0] BI   = 8'h10;
    localparam logic [7:0] BO   = 8'h20;
    localparam logic [7:0] ST   = 8'hFF;
    localparam logic [7:0] ORST = 8'hA5;
`ifdef IO_HUB_SNAPSHOT_EN
    localparam logic [7:0] SNAP_EXP = 8'h55;
`else
    localparam logic [7:0] SNAP_EXP = 8'hAA;
`endif

    typedef struct {
        logic [7:0]     rd;
        logic           irq;
        logic [NO*8-1:0] outs;
        logic [NO-1:0]  wr;
        logic [NI-1:0]  rdp;
    } exp_t;

    logic            sysclk = 1'b0;
    logic            sysreset;
    logic            upd_sysregs;
    logic [NI*8-1:0] in_regs;
    logic [NO*8-1:0] out_regs;
    logic [NO-1:0]   out_wr;
    logic [NI-1:0]   in_rd;

    picoblaze_io_hub_if bus ();

    picoblaze_io_hub #(
        .NUM_IN(NI), .NUM_OUT(NO), .BASE_IN(BI), .BASE_OUT(BO),
        .STATUS_PORT(ST), .OUT_RESET(ORST)
    ) dut (
        .sysclk      (sysclk),
        .sysreset    (sysreset),
        .bus         (bus),
        .upd_sysregs (upd_sysregs),
        .in_regs     (in_regs),
        .out_regs    (out_regs),
        .out_wr      (out_wr),
        .in_rd       (in_rd)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;
    exp_t expq[$];

    // reference model state
    logic [7:0] m_out [NO];
    logic [7:0] m_sh  [NI];
    logic [7:0] live  [NI];
    int         m_ovr;
    bit         m_pend;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // one processor cycle: drive inputs, advance the model, queue the expected outputs
    task automatic cyc(input logic [7:0] pid, input logic ws, ks, rs,
                       input logic [7:0] din, input logic ack, upd, rst);
        exp_t e;
        int off, j;
        @(negedge sysclk);
        bus.port_id = pid; bus.write_strobe = ws; bus.k_write_strobe = ks;
        bus.read_strobe = rs; bus.io_data_in = din; bus.interrupt_ack = ack;
        upd_sysregs = upd; sysreset = rst;
        for (int i = 0; i < NI; i++) in_regs[8*i +: 8] = live[i];
        e.wr = '0; e.rdp = '0;
        if (rst) begin
            foreach (m_out[k]) m_out[k] = ORST;
            foreach (m_sh[k]) m_sh[k] = 8'h00;
            m_ovr = 0; m_pend = 0;
            e.rd = 8'h00;
        end else begin
            off = int'(pid) - int'(BI);
            j = -1;
            if (pid == ST) e.rd = {m_pend, 7'(m_ovr)};
            else if (off >= 0 && off < NI) begin
`ifdef IO_HUB_SNAPSHOT_EN
                e.rd = m_sh[off];
`else
                e.rd = live[off];
`endif
                if (rs) e.rdp[off] = 1'b1;
            end else e.rd = 8'h00;
            if (ws && int'(pid) >= int'(BO) && int'(pid) < int'(BO) + NO) j = int'(pid) - int'(BO);
            else if (ks && int'(pid[3:0]) < NO) j = int'(pid[3:0]);
            if (j >= 0) begin
                m_out[j] = din;
                e.wr[j] = 1'b1;
            end
            if (rs && pid == ST) m_ovr = 0;
            if (m_pend && upd && !ack) m_ovr = (m_ovr < 127) ? m_ovr + 1 : 127;
            m_pend = upd || (m_pend && !ack);
            if (upd) m_sh = live;
        end
        e.irq = m_pend;
        for (int k = 0; k < NO; k++) e.outs[8*k +: 8] = m_out[k];
        expq.push_back(e);
    endtask

    task automatic settle();
        @(posedge sysclk);
        #1;
    endtask

    // monitor: outputs are presented every cycle, compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge sysclk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("io_data_out", 64'(bus.io_data_out), 64'(e.rd));
                chk("interrupt", 64'(bus.interrupt), 64'(e.irq));
                chk("out_regs", 64'(out_regs), 64'(e.outs));
                chk("out_wr", 64'(out_wr), 64'(e.wr));
                chk("in_rd", 64'(in_rd), 64'(e.rdp));
            end
        end
    end

    initial begin
        int r, s;
        logic [7:0] pid;
        bus.port_id = 0; bus.write_strobe = 0; bus.k_write_strobe = 0; bus.read_strobe = 0;
        bus.io_data_in = 0; bus.interrupt_ack = 0; upd_sysregs = 0; sysreset = 1; in_regs = '0;
        foreach (live[k]) live[k] = 8'($urandom);
        // reset
        cyc(8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
        cyc(8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
        cyc(ST, 0, 0, 0, 8'h00, 0, 0, 0);
        settle();
        chk("reset_status", 64'(bus.io_data_out), 64'h00);
        chk("reset_outs", 64'(out_regs), {8{ORST}});
        chk("reset_irq", 64'(bus.interrupt), 64'h0);
        // OUTPUT decode
        cyc(BO + 8'd3, 1, 0, 0, 8'h3C, 0, 0, 0);
        settle();
        chk("wr_pulse", 64'(out_wr), 64'h08);
        chk("wr_data", 64'(out_regs[31:24]), 64'h3C);
        cyc(8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
        settle();
        chk("wr_pulse_end", 64'(out_wr), 64'h00);
        // OUTPUTK decode
        cyc(8'hF2, 0, 1, 0, 8'h11, 0, 0, 0);
        settle();
        chk("kwr_data", 64'(out_regs[23:16]), 64'h11);
        // snapshot and interrupt handshake
        live[1] = 8'h55;
        cyc(8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
        settle();
        chk("irq_rise", 64'(bus.interrupt), 64'h1);
        live[1] = 8'hAA;
        cyc(8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
        settle();
        chk("irq_fall", 64'(bus.interrupt), 64'h0);
        cyc(BI + 8'd1, 0, 0, 1, 8'h00, 0, 0, 0);
        settle();
        chk("snap_read", 64'(bus.io_data_out), 64'(SNAP_EXP));
        chk("snap_in_rd", 64'(in_rd), 64'h02);
        // overrun count and clear-on-read
        repeat (3) cyc(8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
        cyc(ST, 0, 0, 1, 8'h00, 0, 0, 0);
        settle();
        chk("ovr_3", 64'(bus.io_data_out), 64'h82);
        cyc(ST, 0, 0, 1, 8'h00, 0, 0, 0);
        settle();
        chk("ovr_clr", 64'(bus.io_data_out), 64'h80);
        // ack and update together while pending
        cyc(8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 8'h00, 1, 1, 0);
        settle();
        chk("simul_irq", 64'(bus.interrupt), 64'h1);
        cyc(ST, 0, 0, 0, 8'h00, 0, 0, 0);
        settle();
        chk("simul_ovr", 64'(bus.io_data_out), 64'h81);
        // saturation
        repeat (130) cyc(8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
        cyc(ST, 0, 0, 0, 8'h00, 0, 0, 0);
        settle();
        chk("ovr_sat", 64'(bus.io_data_out), 64'hFF);
        // clear coinciding with an increment leaves 1
        cyc(ST, 0, 0, 1, 8'h00, 0, 1, 0);
        cyc(ST, 0, 0, 0, 8'h00, 0, 0, 0);
        settle();
        chk("clr_inc", 64'(bus.io_data_out), 64'h81);
        cyc(8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
        // randomized traffic, including occasional mid-transaction resets
        repeat (2000) begin
            r = $urandom_range(0, 3);
            pid = r == 0 ? BI + 8'($urandom_range(0, 9)) :
                  r == 1 ? BO + 8'($urandom_range(0, 9)) :
                  r == 2 ? ST : 8'($urandom);
            s = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) live[$urandom_range(0, NI-1)] = 8'($urandom);
            cyc(pid, s == 1, s == 2, s == 3, 8'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (3) @(negedge sysclk);
        chk("drain", 64'(expq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/picoblaze_io_hub.md
# picoblaze_io_hub

Parametrised PicoBlaze (KCPSM6) port-I/O hub: the next generation of the bot interface block. It sits between the processor port bus and the system peripherals and exposes NUM_IN read registers and NUM_OUT write registers behind configurable base addresses. On each system-register update strobe it captures a coherent snapshot of all read registers and raises a latched interrupt. Missed updates are counted in an overrun counter the firmware can read.

## Interface
Parameters:
- NUM_IN, 8: number of 8-bit read registers (1..32).
- NUM_OUT, 8: number of 8-bit write registers (1..16).
- BASE_IN, 8'h00: port_id of read register 0.
- BASE_OUT, 8'h00: port_id of write register 0.
- STATUS_PORT, 8'hFF: read-only status port.
- OUT_RESET, 8'h00: reset value of every write register.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- sysreset  in  1  synchronous, active-high reset.
- port_id  in  8  processor port address.
- write_strobe  in  1  OUTPUT strobe.
- k_write_strobe  in  1  OUTPUTK strobe (constant-optimised).
- read_strobe  in  1  INPUT strobe.
- io_data_in  in  8  processor out_port.
- io_data_out  out  8  to processor in_port; registered.
- interrupt  out  1  latched interrupt request.
- interrupt_ack  in  1  processor acknowledge.
- upd_sysregs  in  1  one-cycle update pulse from the peripheral side.
- in_regs  in  NUM_IN*8  flattened read registers; register i is bits [8i+7:8i].
- out_regs  out  NUM_OUT*8  flattened write registers.
- out_wr  out  NUM_OUT  one-cycle pulse per written register.
- in_rd  out  NUM_IN  one-cycle pulse per read register read.

## Operation
- **Reset:**
  - io_data_out = 0, interrupt = 0, overrun = 0.
  - out_regs = OUT_RESET replicated; out_wr = 0; in_rd = 0.
  - Shadow registers = 0.
- **Snapshot:** when upd_sysregs = 1, all NUM_IN shadow registers load in_regs in the same edge.
- **Read decode:**
  - io_data_out is reloaded every cycle from port_id.
  - port_id in [BASE_IN, BASE_IN+NUM_IN) selects shadow[port_id-BASE_IN].
  - port_id == STATUS_PORT returns {interrupt, overrun[6:0]}.
  - Any other address returns 8'h00.
  - STATUS_PORT takes precedence over an overlapping range.
- **Read side effects:**
  - read_strobe on a read-range address pulses in_rd[i] for one cycle.
  - read_strobe on STATUS_PORT clears overrun at the following edge. An overrun increment in that same cycle wins, so overrun ends at 1.
- **Write:**
  - write_strobe with port_id in [BASE_OUT, BASE_OUT+NUM_OUT) loads io_data_in into out_regs[j] and pulses out_wr[j].
  - k_write_strobe decodes port_id[3:0] only as j; it is ignored if j >= NUM_OUT.
  - Out-of-range writes are ignored.
- **Interrupt FSM, states IDLE and PEND:**
  - IDLE --upd_sysregs--> PEND.
  - PEND --interrupt_ack & !upd_sysregs--> IDLE.
  - PEND --upd_sysregs--> PEND and overrun += 1. overrun is a 7-bit counter that saturates at 127.
  - If interrupt_ack and upd_sysregs occur in the same cycle in PEND, the state stays PEND and the overrun counter does not increment. The new event replaces the acknowledged one.
  - interrupt = (state == PEND).
- A reset mid-transaction aborts it: no out_wr pulse is issued and a pending interrupt is dropped.

## Timing
- Read latency is 1 cycle from port_id to io_data_out. This meets KCPSM6 sampling of in_port two cycles after port_id becomes valid.
- Write latency: out_regs and out_wr update at the edge after the strobe cycle.
- Shadow registers are updated at the edge where upd_sysregs is sampled. A read addressed in the same cycle returns the old snapshot.
- Interrupt latency: interrupt rises 1 cycle after upd_sysregs and falls 1 cycle after interrupt_ack.
- out_wr and in_rd are single-cycle pulses with no back-to-back merging.

## Configuration
- **IO_HUB_SNAPSHOT_EN defined:** shadow registers exist; reads return data captured at the last upd_sysregs.
- **IO_HUB_SNAPSHOT_EN undefined:** no shadow registers; reads return live in_regs. The interrupt and overrun logic is unchanged.

## Structure
- Package io_hub_pkg holds:
  - the interrupt state encoding (IDLE/PEND);
  - the overrun counter width (7) and its saturation constant;
  - the default STATUS_PORT value.
- One sub-module, io_hub_irq, contains the interrupt FSM and the overrun counter. Its ports are sysclk, sysreset, upd_sysregs, interrupt_ack, clr_overrun, interrupt and overrun.
- Address decode, the read mux and the write registers stay in the top level.

## Test plan
- **Reset:** assert sysreset for 2 cycles with OUT_RESET = 8'hA5 -> every out_regs byte = 8'hA5, interrupt = 0, reading STATUS_PORT returns 8'h00.
- **Write decode:**
  - write_strobe with port_id = BASE_OUT+3 and data 8'h3C -> out_regs[3] = 8'h3C and out_wr = 1<<3 for exactly 1 cycle.
  - k_write_strobe with port_id = 8'hF2 and data 8'h11 -> out_regs[2] = 8'h11.
- **Snapshot:** set in_regs[1] = 8'h55, pulse upd_sysregs, then set in_regs[1] = 8'hAA -> INPUT at BASE_IN+1 returns 8'h55, and in_rd[1] pulses.
- **Interrupt handshake:** pulse upd_sysregs -> interrupt = 1 on the next cycle; pulse interrupt_ack -> interrupt = 0 on the next cycle.
- **Overrun:** 3 upd_sysregs pulses with no ack -> STATUS_PORT reads 8'h82; the next status read returns 8'h80. 130 pulses -> overrun saturates at 127 (status 8'hFF).
- **Simultaneous events:** interrupt_ack and upd_sysregs in the same cycle while PEND -> interrupt stays 1 and overrun is unchanged.
